// File: rtl/sprite_ram_arbiter.sv
// sprite_ram_arbiter: shares one sync-read sprite RAM between round-robin pixel fetchers and a capped-priority loader
module sprite_ram_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 24,
    parameter int MEM_DEPTH = 2500,
    parameter int WR_BURST  = 4
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_err,
    input  logic                      wr_req,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      wr_ack,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_write_address,
    output logic [ADDR_W-1:0]         ram_read_address,
    output logic [DATA_W-1:0]         ram_data_In,
    input  logic [DATA_W-1:0]         ram_data_Out
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = $clog2(WR_BURST + 1);
    logic [IW-1:0]      ptr, pick, tag_idx;
    logic [SW-1:0]      streak;
    logic [NUM_REQ-1:0] elig;
    logic [ADDR_W-1:0]  pick_addr;
    logic               pick_ok, sel_wr, sel_rd, tag_vld, tag_err;
    // last cycle's grantee still shows req while it reacts, so it sits out one cycle
    assign elig = req & ~gnt;
    always_comb begin
        pick = '0;
        pick_ok = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (elig[(int'(ptr) + k) % NUM_REQ]) begin
                pick_ok = 1'b1;
                pick = IW'((int'(ptr) + k) % NUM_REQ);
            end
    end
    assign pick_addr = req_addr[int'(pick) * ADDR_W +: ADDR_W];
    assign sel_wr = wr_req && (streak < SW'(WR_BURST) || !(|req));
    assign sel_rd = !sel_wr && pick_ok;
    assign rd_data = (|rd_valid && !rd_err) ? ram_data_Out : '0;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            gnt <= '0;
            rd_valid <= '0;
            rd_err <= 1'b0;
            wr_ack <= 1'b0;
            ram_we <= 1'b0;
            ram_write_address <= '0;
            ram_read_address <= '0;
            ram_data_In <= '0;
            ptr <= '0;
            streak <= '0;
            tag_vld <= 1'b0;
            tag_idx <= '0;
            tag_err <= 1'b0;
        end else begin
            gnt <= sel_rd ? NUM_REQ'(1) << pick : '0;
            wr_ack <= sel_wr;
            ram_we <= sel_wr && wr_addr < ADDR_W'(MEM_DEPTH);
            // tag rides one stage behind the issue so it lines up with the RAM's read latency
            tag_vld <= sel_rd;
            tag_idx <= pick;
            tag_err <= pick_addr >= ADDR_W'(MEM_DEPTH);
            rd_valid <= tag_vld ? NUM_REQ'(1) << tag_idx : '0;
            rd_err <= tag_vld && tag_err;
            if (sel_wr) begin
                ram_write_address <= wr_addr;
                ram_data_In <= wr_data;
                streak <= !(|req) ? '0 : (streak == SW'(WR_BURST) ? streak : streak + 1'b1);
            end
            if (sel_rd) begin
                ram_read_address <= pick_addr;
                ptr <= pick == IW'(NUM_REQ - 1) ? '0 : pick + 1'b1;
                streak <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// tb_sprite_ram_arbiter: directed stimulus with a cycle-level reference model and a RAM model
module tb_sprite_ram_arbiter;
    localparam int N = 4, AW = 19, DW = 24, DEPTH = 2500, WB = 4;
    logic            Clk = 1'b0, Reset_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic            wr_req = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic [N-1:0]    gnt, rd_valid;
    logic [DW-1:0]   rd_data, ram_data_In, ram_data_Out = '0, ram_rd_tmp;
    logic            rd_err, wr_ack, ram_we;
    logic [AW-1:0]   ram_write_address, ram_read_address;
    int errors = 0, checks = 0;

    sprite_ram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .WR_BURST(WB)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .req(req), .req_addr(req_addr), .gnt(gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .ram_we(ram_we),
        .ram_write_address(ram_write_address), .ram_read_address(ram_read_address),
        .ram_data_In(ram_data_In), .ram_data_Out(ram_data_Out));

    initial forever #5 Clk = ~Clk;

    function automatic logic [DW-1:0] init_word(input int a);
        return 24'hC00000 | 24'(a & 16'hFFFF);
    endfunction

    // sprite RAM: sync read, written words override the power-up pattern
    logic [DW-1:0] ram [int];
    initial forever begin
        @(posedge Clk);
        ram_rd_tmp = ram.exists(int'(ram_read_address)) ? ram[int'(ram_read_address)] : init_word(int'(ram_read_address));
        if (ram_we) ram[int'(ram_write_address)] = ram_data_In;
        ram_data_Out <= ram_rd_tmp;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    // reference model: arbitration rules applied to sampled inputs, returns held in a queue
    typedef struct { int due; int idx; logic [DW-1:0] data; logic err; } ret_t;
    ret_t q[$];
    logic [DW-1:0] refmem [int];
    int cyc = 0, ptr = 0, streak = 0, last = -1;
    logic [N-1:0]  e_gnt = '0, e_rv = '0;
    logic          e_wack = 1'b0, e_we = 1'b0, e_rerr = 1'b0;
    logic [AW-1:0] e_waddr = '0, e_raddr = '0;
    logic [DW-1:0] e_wdata = '0, e_rdata = '0;

    task automatic model_step();
        int cand, a;
        bit any, oor;
        ret_t r;
        cyc++;
        if (!Reset_n) begin
            ptr = 0; streak = 0; last = -1; q.delete();
            e_gnt = '0; e_rv = '0; e_wack = 0; e_we = 0; e_rerr = 0;
            e_waddr = '0; e_raddr = '0; e_wdata = '0; e_rdata = '0;
            return;
        end
        e_rv = '0; e_rdata = '0; e_rerr = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            e_rv = N'(1) << r.idx; e_rdata = r.data; e_rerr = r.err;
        end
        any = |req;
        cand = -1;
        for (int k = 0; k < N; k++)
            if (cand < 0 && req[(ptr + k) % N] && (ptr + k) % N != last) cand = (ptr + k) % N;
        e_gnt = '0; e_wack = 1'b0; e_we = 1'b0;
        if (wr_req && (streak < WB || !any)) begin
            e_wack = 1'b1;
            e_we = int'(wr_addr) < DEPTH;
            e_waddr = wr_addr; e_wdata = wr_data;
            if (e_we) refmem[int'(wr_addr)] = wr_data;
            streak = any ? (streak < WB ? streak + 1 : WB) : 0;
            last = -1;
        end else if (cand >= 0) begin
            a = int'(req_addr[cand*AW +: AW]);
            oor = a >= DEPTH;
            e_gnt = N'(1) << cand;
            e_raddr = AW'(a);
            q.push_back('{due: cyc + 1, idx: cand, err: oor,
                          data: oor ? '0 : (refmem.exists(a) ? refmem[a] : init_word(a))});
            ptr = (cand + 1) % N; streak = 0; last = cand;
        end else last = -1;
    endtask

    initial forever begin
        @(posedge Clk);
        model_step();
    end

    initial forever begin
        @(negedge Clk);
        chk("gnt", gnt, Reset_n ? e_gnt : '0);
        chk("wr_ack", wr_ack, Reset_n ? e_wack : 1'b0);
        chk("ram_we", ram_we, Reset_n ? e_we : 1'b0);
        chk("ram_read_address", ram_read_address, Reset_n ? e_raddr : '0);
        chk("rd_valid", rd_valid, Reset_n ? e_rv : '0);
        chk("rd_err", rd_err, Reset_n ? e_rerr : 1'b0);
        chk("rd_data", rd_data, Reset_n ? e_rdata : '0);
        if (Reset_n && e_we) begin
            chk("ram_write_address", ram_write_address, e_waddr);
            chk("ram_data_In", ram_data_In, e_wdata);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic set_req(input int i, input int a);
        req[i] = 1'b1;
        req_addr[i*AW +: AW] = AW'(a);
    endtask

    // sel 0: gnt[b], 1: rd_valid[b], 2: wr_ack; bounded to 10 cycles
    task automatic wait_for(input int sel, input int b, input string nm);
        for (int t = 0; t < 10; t++) begin
            tick();
            if ((sel == 0 && gnt[b]) || (sel == 1 && rd_valid[b]) || (sel == 2 && wr_ack)) return;
        end
        chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        int order[$];
        int ev[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int exp_ev[9] = '{1, 1, 1, 1, 2, 1, 1, 1, 1};
        int g2, gx, rv2, nw;
        bit seen;
        repeat (3) tick();
        chk("reset_outputs", {gnt, rd_valid, wr_ack, ram_we, rd_err}, '0);
        Reset_n = 1'b1;
        tick();

        for (int i = 0; i < N; i++) set_req(i, 10 * (i + 1));
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
            if (rd_valid[0] && !seen) begin
                seen = 1;
                chk("rr_first_data", rd_data, 24'hC0000A);
            end
        end
        chk("rr_grant_count", order.size(), 12);
        for (int k = 0; k < 5; k++) chk("rr_order", order[k], exp_order[k]);
        req = '0;
        repeat (2) tick();

        set_req(2, 5);
        g2 = 0; gx = 0; rv2 = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            g2 += int'(gnt[2]);
            gx += int'(gnt[0]) + int'(gnt[1]) + int'(gnt[3]);
            if (rd_valid[2]) begin
                rv2++;
                chk("solo_data", rd_data, 24'hC00005);
            end
        end
        chk("solo_gnt_count", g2, 5);
        chk("solo_other_gnt", gx, 0);
        chk("solo_rv_count", rv2, 5);
        req = '0;
        repeat (2) tick();

        set_req(0, 3);
        wr_req = 1'b1; wr_addr = '0; wr_data = 24'h100000;
        nw = 0; seen = 0;
        for (int t = 0; t < 14; t++) begin
            tick();
            if (wr_ack) ev.push_back(1);
            if (gnt[0]) ev.push_back(2);
            if (rd_valid[0] && !seen) begin
                seen = 1;
                chk("burst_raw_data", rd_data, 24'h100003);
            end
            if (wr_ack) begin
                nw++;
                if (nw == 8) wr_req = 1'b0;
                else begin
                    wr_addr = AW'(nw);
                    wr_data = 24'h100000 | DW'(nw);
                end
            end
        end
        for (int k = 0; k < 9; k++) chk("burst_pattern", ev[k], exp_ev[k]);
        chk("burst_writes", nw, 8);
        req = '0;
        repeat (3) tick();

        wr_req = 1'b1; wr_addr = 100; wr_data = 24'hABCDEF;
        wait_for(2, 0, "raw_wack");
        wr_req = 1'b0;
        set_req(1, 100);
        wait_for(0, 1, "raw_gnt");
        req = '0;
        wait_for(1, 1, "raw_rv");
        chk("raw_data", rd_data, 24'hABCDEF);
        chk("raw_err", rd_err, 1'b0);

        set_req(3, 2500);
        wait_for(0, 3, "oor_gnt");
        req = '0;
        wait_for(1, 3, "oor_rv");
        chk("oor_valid", rd_valid, 4'b1000);
        chk("oor_data", rd_data, 24'h0);
        chk("oor_err", rd_err, 1'b1);
        set_req(2, 2499);
        wait_for(0, 2, "edge_gnt");
        req = '0;
        wait_for(1, 2, "edge_rv");
        chk("edge_data", rd_data, 24'hC009C3);
        chk("edge_err", rd_err, 1'b0);
        wr_req = 1'b1; wr_addr = 3000; wr_data = 24'h123456;
        wait_for(2, 0, "oor_wack");
        chk("oor_wr_we", ram_we, 1'b0);
        wr_req = 1'b0;
        repeat (2) tick();

        set_req(0, 10);
        set_req(1, 20);
        wait_for(0, 0, "rst_gnt0");
        Reset_n = 1'b0;
        req = '0;
        #1;
        chk("rst_gnt_clear", gnt, 4'b0000);
        repeat (2) tick();
        Reset_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("rst_no_valid", rd_valid, 4'b0000);
        end
        set_req(0, 10);
        set_req(1, 20);
        tick();
        chk("rst_ptr_zero", gnt, 4'b0001);
        req[0] = 1'b0;
        tick();
        chk("rst_next_rr", gnt, 4'b0010);
        req = '0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
